// File: rtl/ibex_multdiv_arb_if.sv
// Bundle between two requesters, the arbiter and the shared mult/div unit.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface ibex_multdiv_arb_if;
  logic [1:0]  req_i;
  logic [1:0]  req_div_i;
  logic [3:0]  req_operator_i;
  logic [3:0]  req_signed_mode_i;
  logic [63:0] req_op_a_i;
  logic [63:0] req_op_b_i;
  logic        kill_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mult_en_o;
  logic        div_en_o;
  logic [1:0]  operator_o;
  logic [1:0]  signed_mode_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic        valid_i;
  logic [31:0] result_i;

  modport slave (
    input  req_i, req_div_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
    input  kill_i, valid_i, result_i,
    output gnt_o, rvalid_o, rdata_o, err_o, mult_en_o, div_en_o,
    output operator_o, signed_mode_o, op_a_o, op_b_o
  );

  modport master (
    output req_i, req_div_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
    output kill_i, valid_i, result_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, mult_en_o, div_en_o,
    input  operator_o, signed_mode_o, op_a_o, op_b_o
  );
endinterface

// File: rtl/ibex_multdiv_arb.sv
// Round-robin arbiter sharing one mult/div unit between two requesters, with watchdog and kill.
// Grant is combinational in IDLE; response one cycle after unit valid; requests wait while busy.
module ibex_multdiv_arb #(
  parameter int unsigned TIMEOUT = 40
) (
  input logic               clk_i,
  input logic               rst_ni,
  ibex_multdiv_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        owner_q, owner_d;
  logic        div_q, div_d;
  logic [1:0]  operator_q, operator_d;
  logic [1:0]  signed_q, signed_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  gnt;
  logic        win;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      div_q      <= 1'b0;
      operator_q <= '0;
      signed_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      div_q      <= div_d;
      operator_q <= operator_d;
      signed_q   <= signed_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      data_q     <= data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    div_d      = div_q;
    operator_d = operator_q;
    signed_d   = signed_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    gnt        = 2'b00;
    // rr_q names the requester that wins a tie
    win        = (bus.req_i == 2'b11) ? rr_q : bus.req_i[1];

    unique case (state_q)
      IDLE: begin
        if (bus.req_i != 2'b00) begin
          gnt        = win ? 2'b10 : 2'b01;
          owner_d    = win;
          rr_d       = ~win;
          div_d      = bus.req_div_i[win];
          operator_d = win ? bus.req_operator_i[3:2]    : bus.req_operator_i[1:0];
          signed_d   = win ? bus.req_signed_mode_i[3:2] : bus.req_signed_mode_i[1:0];
          op_a_d     = win ? bus.req_op_a_i[63:32]      : bus.req_op_a_i[31:0];
          op_b_d     = win ? bus.req_op_b_i[63:32]      : bus.req_op_b_i[31:0];
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.kill_i) begin
          state_d = IDLE;
        end else if (bus.valid_i) begin
          data_d  = bus.result_i;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == WdLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state_q already reads IDLE under reset, but gnt is combinational on req_i
  assign bus.gnt_o         = gnt & {2{rst_ni}};
  assign bus.mult_en_o     = (state_q == BUSY) && !div_q;
  assign bus.div_en_o      = (state_q == BUSY) && div_q;
  assign bus.operator_o    = operator_q;
  assign bus.signed_mode_o = signed_q;
  assign bus.op_a_o        = op_a_q;
  assign bus.op_b_o        = op_b_q;
  assign bus.rvalid_o      = (state_q != DONE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign bus.rdata_o       = (state_q == DONE) ? data_q : 32'd0;
  assign bus.err_o         = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_ibex_multdiv_arb.sv
// Directed bench for ibex_multdiv_arb: inputs change on the falling edge, outputs sampled 1 ns later.
module tb_ibex_multdiv_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ibex_multdiv_arb_if bus ();

  ibex_multdiv_arb #(.TIMEOUT(40)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic clear_inputs();
    bus.req_i = '0; bus.req_div_i = '0; bus.req_operator_i = '0; bus.req_signed_mode_i = '0;
    bus.req_op_a_i = '0; bus.req_op_b_i = '0; bus.kill_i = 1'b0; bus.valid_i = 1'b0;
    bus.result_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; clear_inputs();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk); bus.req_i = 2'b11; #1;
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.gnt_o); end
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", bus.rvalid_o); end
    checks++; if ({bus.mult_en_o, bus.div_en_o, bus.err_o} !== 3'b000) begin errors++; $display("FAIL reset_en: got %b want 000", {bus.mult_en_o, bus.div_en_o, bus.err_o}); end
    checks++; if ({bus.op_a_o, bus.op_b_o, bus.rdata_o} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.op_a_o, bus.op_b_o, bus.rdata_o}); end
    @(negedge clk); rst_n = 1'b1; bus.req_i = 2'b00;
  endtask

  task automatic test_single_mult();
    @(negedge clk);
    bus.req_i = 2'b01; bus.req_div_i = 2'b00; bus.req_operator_i = 4'b0111; bus.req_signed_mode_i = 4'b1001;
    bus.req_op_a_i = {32'hDEAD, 32'd7}; bus.req_op_b_i = {32'hBEEF, 32'd6};
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", bus.gnt_o); end
    checks++; if (bus.mult_en_o !== 1'b0) begin errors++; $display("FAIL single_idle_en: got %b want 0", bus.mult_en_o); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.req_i = 2'b00; bus.req_op_a_i = '0; bus.req_op_b_i = '0; bus.req_operator_i = '0;
      bus.valid_i = (c == 5); bus.result_i = (c == 5) ? 32'd42 : 32'd999;
      #1;
      checks++; if ({bus.mult_en_o, bus.div_en_o} !== 2'b10) begin errors++; $display("FAIL single_en c%0d: got %b want 10", c, {bus.mult_en_o, bus.div_en_o}); end
      checks++; if ({bus.op_a_o, bus.op_b_o} !== {32'd7, 32'd6}) begin errors++; $display("FAIL single_ops c%0d: got %h want 7/6", c, {bus.op_a_o, bus.op_b_o}); end
      checks++; if ({bus.operator_o, bus.signed_mode_o} !== 4'b1101) begin errors++; $display("FAIL single_opr c%0d: got %b want 1101", c, {bus.operator_o, bus.signed_mode_o}); end
      checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL single_busy_rvalid c%0d: got %b want 00", c, bus.rvalid_o); end
    end
    @(negedge clk); bus.valid_i = 1'b0; #1;
    checks++; if (bus.rvalid_o !== 2'b01) begin errors++; $display("FAIL single_rvalid: got %b want 01", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'd42) begin errors++; $display("FAIL single_rdata: got %0d want 42", bus.rdata_o); end
    checks++; if ({bus.err_o, bus.mult_en_o} !== 2'b00) begin errors++; $display("FAIL single_done_flags: got %b want 00", {bus.err_o, bus.mult_en_o}); end
    @(negedge clk); #1;
    checks++; if ({bus.rvalid_o, bus.rdata_o} !== 34'd0) begin errors++; $display("FAIL single_after: got %h want 0", {bus.rvalid_o, bus.rdata_o}); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      bus.req_i = 2'b11; bus.req_div_i = 2'b00; bus.req_op_a_i = {32'd22, 32'd11}; bus.valid_i = 1'b0;
      #1;
      checks++; if (bus.gnt_o !== exp_g) begin errors++; $display("FAIL cont_gnt k%0d: got %b want %b", k, bus.gnt_o, exp_g); end
      @(negedge clk); bus.valid_i = 1'b1; bus.result_i = 32'd100 + 32'(k); #1;
      checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL cont_busy_gnt k%0d: got %b want 00", k, bus.gnt_o); end
      checks++; if (bus.op_a_o !== ((k % 2 == 0) ? 32'd11 : 32'd22)) begin errors++; $display("FAIL cont_op_a k%0d: got %0d", k, bus.op_a_o); end
      @(negedge clk); bus.valid_i = 1'b0; #1;
      checks++; if (bus.rvalid_o !== exp_g) begin errors++; $display("FAIL cont_rvalid k%0d: got %b want %b", k, bus.rvalid_o, exp_g); end
      checks++; if (bus.rdata_o !== 32'd100 + 32'(k)) begin errors++; $display("FAIL cont_rdata k%0d: got %0d want %0d", k, bus.rdata_o, 100 + k); end
      checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL cont_done_gnt k%0d: got %b want 00", k, bus.gnt_o); end
    end
    bus.req_i = 2'b00;
  endtask

  task automatic test_timeout();
    int n = 0;
    @(negedge clk); bus.req_i = 2'b10; bus.req_div_i = 2'b10; bus.valid_i = 1'b0; #1;
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL to_gnt: got %b want 10", bus.gnt_o); end
    @(negedge clk); bus.req_i = 2'b00; #1;
    while (bus.div_en_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    checks++; if (n !== 40) begin errors++; $display("FAIL to_cycles: got %0d want 40", n); end
    checks++; if (bus.rvalid_o !== 2'b10) begin errors++; $display("FAIL to_rvalid: got %b want 10", bus.rvalid_o); end
    checks++; if ({bus.err_o, bus.rdata_o} !== {1'b1, 32'd0}) begin errors++; $display("FAIL to_err_data: got %b/%0d want 1/0", bus.err_o, bus.rdata_o); end
  endtask

  task automatic test_kill();
    @(negedge clk); bus.req_i = 2'b01; bus.req_div_i = 2'b00; bus.kill_i = 1'b1; #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL kill_idle_gnt: got %b want 01", bus.gnt_o); end
    @(negedge clk); bus.req_i = 2'b11; bus.kill_i = 1'b0; #1;
    checks++; if (bus.mult_en_o !== 1'b1) begin errors++; $display("FAIL kill_busy: got %b want 1", bus.mult_en_o); end
    @(negedge clk); bus.kill_i = 1'b1; bus.valid_i = 1'b1; bus.result_i = 32'd55; #1;
    @(negedge clk); bus.kill_i = 1'b0; bus.valid_i = 1'b0; #1;
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL kill_rvalid: got %b want 00", bus.rvalid_o); end
    checks++; if (bus.mult_en_o !== 1'b0) begin errors++; $display("FAIL kill_idle_en: got %b want 0", bus.mult_en_o); end
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL kill_regrant: got %b want 10", bus.gnt_o); end
    @(negedge clk); bus.req_i = 2'b00; bus.valid_i = 1'b1; bus.result_i = 32'd77; #1;
    @(negedge clk); bus.valid_i = 1'b0; bus.kill_i = 1'b1; #1;
    checks++; if ({bus.rvalid_o, bus.rdata_o} !== {2'b10, 32'd77}) begin errors++; $display("FAIL kill_done: got %b/%0d want 10/77", bus.rvalid_o, bus.rdata_o); end
    @(negedge clk); bus.kill_i = 1'b0; #1;
  endtask

  task automatic test_reset_midop();
    @(negedge clk); bus.req_i = 2'b10; bus.req_div_i = 2'b10; bus.req_op_a_i = {32'h55, 32'h66}; #1;
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL rmid_gnt: got %b want 10", bus.gnt_o); end
    @(negedge clk); bus.req_i = 2'b11; #1;
    checks++; if (bus.div_en_o !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b want 1", bus.div_en_o); end
    #2; rst_n = 1'b0; #1;
    checks++; if ({bus.gnt_o, bus.rvalid_o, bus.mult_en_o, bus.div_en_o, bus.err_o} !== 7'd0) begin errors++; $display("FAIL rmid_ctl: got %b want 0", {bus.gnt_o, bus.rvalid_o, bus.mult_en_o, bus.div_en_o, bus.err_o}); end
    checks++; if ({bus.op_a_o, bus.operator_o, bus.signed_mode_o} !== 36'd0) begin errors++; $display("FAIL rmid_data: got %h want 0", {bus.op_a_o, bus.operator_o, bus.signed_mode_o}); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL rmid_regrant: got %b want 01", bus.gnt_o); end
    @(negedge clk); bus.req_i = 2'b00; bus.valid_i = 1'b1; bus.result_i = 32'd5; #1;
    @(negedge clk); bus.valid_i = 1'b0; #1;
    checks++; if ({bus.rvalid_o, bus.rdata_o} !== {2'b01, 32'd5}) begin errors++; $display("FAIL rmid_resp: got %b/%0d want 01/5", bus.rvalid_o, bus.rdata_o); end
  endtask

  task automatic test_operand_stability();
    @(negedge clk);
    bus.req_i = 2'b01; bus.req_div_i = 2'b01; bus.req_operator_i = 4'b0010;
    bus.req_op_a_i = {32'h0, 32'hA5A5_0001}; bus.req_op_b_i = {32'h0, 32'h1234}; #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL stab_gnt: got %b want 01", bus.gnt_o); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.req_i = 2'b00; bus.req_op_a_i = {$urandom, $urandom}; bus.req_op_b_i = {$urandom, $urandom};
      bus.req_operator_i = 4'($urandom); bus.valid_i = (i == 5); bus.result_i = 32'd3;
      #1;
      checks++; if ({bus.op_a_o, bus.op_b_o} !== {32'hA5A5_0001, 32'h1234}) begin errors++; $display("FAIL stab_ops i%0d: got %h", i, {bus.op_a_o, bus.op_b_o}); end
      checks++; if ({bus.operator_o, bus.div_en_o, bus.mult_en_o} !== 4'b1010) begin errors++; $display("FAIL stab_ctl i%0d: got %b want 1010", i, {bus.operator_o, bus.div_en_o, bus.mult_en_o}); end
    end
    @(negedge clk); bus.valid_i = 1'b0; #1;
    checks++; if ({bus.rvalid_o, bus.rdata_o} !== {2'b01, 32'd3}) begin errors++; $display("FAIL stab_resp: got %b/%0d want 01/3", bus.rvalid_o, bus.rdata_o); end
    @(negedge clk); bus.valid_i = 1'b1; bus.result_i = 32'd9; #1;
    @(negedge clk); bus.valid_i = 1'b0; #1;
    checks++; if ({bus.rvalid_o, bus.mult_en_o, bus.div_en_o, bus.rdata_o} !== 36'd0) begin errors++; $display("FAIL stray_valid: got %h want 0", {bus.rvalid_o, bus.mult_en_o, bus.div_en_o, bus.rdata_o}); end
  endtask

  initial begin
    test_reset();
    test_single_mult();
    test_contention();
    test_timeout();
    test_kill();
    test_reset_midop();
    test_operand_stability();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
